vga_fb_arbiter: RTL and testbench

//  Shares one single-port frame-buffer RAM between two requesters: the VGA scan-out reader
//  (hard real-time, issues one read per 4-clk pixel period) and the waveform draw client
//  (writes RRRGGGBB pixels). Scan reads always win; draw writes fill the idle slots.

---
 rtl/vga_fb_arbiter.sv | 84 ++++++++
 tb/tb_vga_fb_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - frame-buffer RAM arbiter: scan-out reads win, draw writes fill idle slots
// Optional VGA_FB_VBLANK_WRITE_EN restricts draw writes to the vertical blanking interval.
module vga_fb_arbiter #(
  parameter int AW = 19,
  parameter int DW = 8,
  parameter int SW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          scan_req,
  input  logic [AW-1:0] scan_addr,
  output logic [DW-1:0] scan_rdata,
  output logic          scan_valid,
  input  logic          vblank,
  input  logic          draw_req,
  input  logic [AW-1:0] draw_addr,
  input  logic [DW-1:0] draw_wdata,
  output logic          draw_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [SW-1:0] stall_cnt
);

`ifdef VGA_FB_VBLANK_WRITE_EN
  localparam logic GATE_VBLANK = 1'b1;
`else
  localparam logic GATE_VBLANK = 1'b0;
`endif

  logic cooldown;
  logic rd_s1;
  logic rd_s2;
  logic draw_eligible;
  logic write_slot;
  logic stall_inc;

  // The ack cycle still sees the served request held high; it is neither re-granted nor a stall.
  always_comb begin
    draw_eligible = draw_req & ~cooldown & (vblank | ~GATE_VBLANK);
    write_slot    = ~scan_req & draw_eligible;
    stall_inc     = draw_req & ~write_slot & ~draw_ack;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      draw_ack   <= 1'b0;
      cooldown   <= 1'b0;
      rd_s1      <= 1'b0;
      rd_s2      <= 1'b0;
      scan_valid <= 1'b0;
      scan_rdata <= '0;
      stall_cnt  <= '0;
    end else begin
      mem_en   <= scan_req | write_slot;
      mem_we   <= write_slot;
      draw_ack <= write_slot;
      cooldown <= write_slot;
      if (scan_req) begin
        mem_addr <= scan_addr;
      end else if (write_slot) begin
        mem_addr  <= draw_addr;
        mem_wdata <= draw_wdata;
      end
      // Read pipeline: RAM enable in N+1, RAM data in N+2, registered to scan-out in N+3.
      rd_s1      <= scan_req;
      rd_s2      <= rd_s1;
      scan_valid <= rd_s2;
      if (rd_s2) begin
        scan_rdata <= mem_rdata;
      end
      if (stall_inc && (stall_cnt != {SW{1'b1}})) begin
        stall_cnt <= stall_cnt + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - scoreboard bench for vga_fb_arbiter
module tb_vga_fb_arbiter;
  localparam int AW = 19;
  localparam int DW = 8;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          scan_req = 1'b0;
  logic [AW-1:0] scan_addr = '0;
  logic          vblank = 1'b0;
  logic          draw_req = 1'b0;
  logic [AW-1:0] draw_addr = '0;
  logic [DW-1:0] draw_wdata = '0;
  logic [DW-1:0] mem_rdata = '0;

  logic [DW-1:0] scan_rdata;
  logic          scan_valid;
  logic          draw_ack;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [SW-1:0] stall_cnt;

  logic [DW-1:0] s_scan_rdata;
  logic          s_scan_valid;
  logic          s_draw_ack;
  logic          s_mem_en;
  logic          s_mem_we;
  logic [AW-1:0] s_mem_addr;
  logic [DW-1:0] s_mem_wdata;
  logic [3:0]    s_stall_cnt;
  logic [DW-1:0] s_mem_rdata = '0;

  always #5 clk = ~clk;

  vga_fb_arbiter #(.AW(AW), .DW(DW), .SW(SW)) dut (
    .clk(clk), .rst_n(rst_n), .scan_req(scan_req), .scan_addr(scan_addr),
    .scan_rdata(scan_rdata), .scan_valid(scan_valid), .vblank(vblank),
    .draw_req(draw_req), .draw_addr(draw_addr), .draw_wdata(draw_wdata),
    .draw_ack(draw_ack), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
  );

  vga_fb_arbiter #(.AW(AW), .DW(DW), .SW(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .scan_req(scan_req), .scan_addr(scan_addr),
    .scan_rdata(s_scan_rdata), .scan_valid(s_scan_valid), .vblank(vblank),
    .draw_req(draw_req), .draw_addr(draw_addr), .draw_wdata(draw_wdata),
    .draw_ack(s_draw_ack), .mem_en(s_mem_en), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
    .mem_wdata(s_mem_wdata), .mem_rdata(s_mem_rdata), .stall_cnt(s_stall_cnt)
  );

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } rd_exp_t;

  typedef struct {
    logic [18:0] addr;
    logic [7:0]  data;
    int          cyc;
  } wr_exp_t;

  rd_exp_t rdq[$];
  wr_exp_t wrq[$];
  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  logic vb;
  logic [7:0] ram [int];

  // Unwritten locations read back as a fixed function of the address.
  function automatic logic [7:0] ram_rd(input int a);
    if (ram.exists(a)) return ram[a];
    return a[7:0] ^ 8'h5A;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en) begin
      if (mem_we) ram[int'(mem_addr)] = mem_wdata;
      else mem_rdata <= ram_rd(int'(mem_addr));
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    rd_exp_t re;
    wr_exp_t we;
    if (rst_n) begin
      if (scan_valid) begin
        if (rdq.size() == 0) chk("spurious_scan_valid", scan_valid, 0);
        else begin
          re = rdq.pop_front();
          chk("scan_rdata", scan_rdata, re.data);
          chk("scan_latency", cyc, re.cyc);
        end
      end
      if (mem_en && mem_we) begin
        if (wrq.size() == 0) chk("spurious_write", mem_we, 0);
        else begin
          we = wrq.pop_front();
          chk("write_addr", mem_addr, we.addr);
          chk("write_data", mem_wdata, we.data);
          chk("write_cycle", cyc, we.cyc);
        end
      end
      if (draw_ack || mem_we) chk("ack_with_write", draw_ack, mem_en & mem_we);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    scan_req = 1'b0;
    draw_req = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_ack();
    bit got;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (draw_ack) got = 1'b1;
    end
    if (!got) chk("ack_timeout", draw_ack, 1);
    tick();
    draw_req = 1'b0;
  endtask

  task automatic scan_one(input logic [18:0] a, input logic [7:0] d);
    scan_req = 1'b1;
    scan_addr = a;
    rdq.push_back('{data: d, cyc: cyc + 3});
    tick();
    scan_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
`ifdef VGA_FB_VBLANK_WRITE_EN
    vb = 1'b1;
`else
    vb = 1'b0;
`endif
    vblank = vb;
    ram[32'h12C00] = 8'hE3;
    do_reset();

    // Reset lands while a read is in flight.
    scan_req = 1'b1;
    scan_addr = 19'h00010;
    tick();
    scan_req = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {mem_en, mem_we, mem_addr, mem_wdata, scan_valid, scan_rdata, draw_ack, stall_cnt}, 64'd0);
    tick();
    tick();
    chk("reset_held_outputs", {mem_en, mem_we, mem_addr, scan_valid, draw_ack}, 64'd0);
    rst_n = 1'b1;
    repeat (5) tick();

    // Single read.
    scan_one(19'h12C00, 8'hE3);
    @(negedge clk);
    chk("read_slot", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 19'h12C00});
    repeat (5) tick();
    chk("rdata_hold", scan_rdata, 8'hE3);

    // One write, request held through the ack cycle, then read back.
    do_reset();
    draw_addr = 19'h00005;
    draw_wdata = 8'h1C;
    draw_req = 1'b1;
    wrq.push_back('{addr: 19'h00005, data: 8'h1C, cyc: cyc + 1});
    wait_ack();
    repeat (4) tick();
    chk("stall_single_write", stall_cnt, 0);
    scan_one(19'h00005, 8'h1C);
    repeat (5) tick();

    // Contention: five back-to-back reads against a held write.
    do_reset();
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          scan_req = 1'b1;
          scan_addr = 19'h00100 + 19'(i);
          rdq.push_back('{data: 8'(i) ^ 8'h5A, cyc: cyc + 3});
          tick();
        end
        scan_req = 1'b0;
      end
      begin
        draw_addr = 19'h00040;
        draw_wdata = 8'hA7;
        draw_req = 1'b1;
        wrq.push_back('{addr: 19'h00040, data: 8'hA7, cyc: cyc + 6});
        wait_ack();
      end
    join
    repeat (5) tick();
    chk("stall_contention", stall_cnt, 5);

    // Saturation: 20 stalled cycles, request abandoned without a write.
    do_reset();
    draw_addr = 19'h00077;
    draw_wdata = 8'h11;
    for (int i = 0; i < 20; i++) begin
      scan_req = 1'b1;
      draw_req = 1'b1;
      scan_addr = 19'h00200 + 19'(i);
      rdq.push_back('{data: 8'(i) ^ 8'h5A, cyc: cyc + 3});
      tick();
    end
    scan_req = 1'b0;
    draw_req = 1'b0;
    repeat (5) tick();
    chk("stall_20", stall_cnt, 20);
    chk("stall_sat_sw4", s_stall_cnt, 15);

`ifdef VGA_FB_VBLANK_WRITE_EN
    // Writes wait for blanking.
    do_reset();
    vblank = 1'b0;
    draw_addr = 19'h00009;
    draw_wdata = 8'h55;
    draw_req = 1'b1;
    wrq.push_back('{addr: 19'h00009, data: 8'h55, cyc: cyc + 12});
    repeat (11) tick();
    vblank = 1'b1;
    wait_ack();
    repeat (3) tick();
    chk("stall_vblank", stall_cnt, 11);
`endif

    repeat (3) tick();
    chk("rd_queue_drained", rdq.size(), 0);
    chk("wr_queue_drained", wrq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
